// File: rtl/btn_if.sv
// Button conditioner bus: raw lines in, debounced level and event pulses out.
// master = conditioner side, slave = button source / event consumer side.
interface btn_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] release_pulse;
  logic [NUM_BTN-1:0] long_press;
  logic [NUM_BTN-1:0] repeat_pulse;

  modport master (
    input  btn,
    output btn_level,
    output press,
    output release_pulse,
    output long_press,
    output repeat_pulse
  );

  modport slave (
    output btn,
    input  btn_level,
    input  press,
    input  release_pulse,
    input  long_press,
    input  repeat_pulse
  );
endinterface

// File: rtl/btn_conditioner.sv
// Per-lane push-button conditioning: synchroniser, debounce, edge events,
// long-press detection and auto-repeat while held.
module btn_conditioner #(
  parameter int NUM_BTN      = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 5000000,
  parameter int ACTIVE_LOW   = 0
) (
  input logic   clk,
  input logic   rst,
  btn_if.master bus
);
  localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] RPT  = 2'd2;

  logic [NUM_BTN-1:0] level_v;
  logic [NUM_BTN-1:0] press_v;
  logic [NUM_BTN-1:0] rel_v;
  logic [NUM_BTN-1:0] long_v;
  logic [NUM_BTN-1:0] rpt_v;

  for (genvar n = 0; n < NUM_BTN; n++) begin : g_lane
    logic          f1;
    logic          f2;
    logic          lvl;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic [1:0]    st;
    logic          press_q;
    logic          rel_q;
    logic          long_q;
    logic          rpt_q;
    logic          s;
    logic          upd;
    logic          rise;
    logic          fall;

    assign s    = f2 ^ INV;
    assign upd  = (s != lvl) && (dcnt == DW'(DEBOUNCE_CYC - 1));
    assign rise = upd & s;
    assign fall = upd & ~s;

    always_ff @(posedge clk) begin
      if (rst) begin
        f1      <= INV;
        f2      <= INV;
        lvl     <= 1'b0;
        dcnt    <= '0;
        hcnt    <= '0;
        st      <= IDLE;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        f1 <= bus.btn[n];
        f2 <= f1;
        if (s == lvl || upd)
          dcnt <= '0;
        else
          dcnt <= dcnt + DW'(1);
        if (upd)
          lvl <= s;
        press_q <= rise;
        rel_q   <= fall;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
        // a falling level overrides any hold timing in the same cycle
        if (fall) begin
          st   <= IDLE;
          hcnt <= '0;
        end else begin
          unique case (st)
            IDLE: begin
              if (rise) begin
                st   <= HOLD;
                hcnt <= HW'(1);
              end
            end
            HOLD: begin
              if (hcnt == HW'(LONG_CYC)) begin
                long_q <= 1'b1;
                hcnt   <= '0;
                st     <= RPT;
              end else begin
                hcnt <= hcnt + HW'(1);
              end
            end
            RPT: begin
              if (hcnt == HW'(REPEAT_CYC - 1)) begin
                rpt_q <= 1'b1;
                hcnt  <= '0;
              end else begin
                hcnt <= hcnt + HW'(1);
              end
            end
            default: begin
              st   <= IDLE;
              hcnt <= '0;
            end
          endcase
        end
      end
    end

    assign level_v[n] = lvl;
    assign press_v[n] = press_q;
    assign rel_v[n]   = rel_q;
    assign long_v[n]  = long_q;
    assign rpt_v[n]   = rpt_q;
  end

  assign bus.btn_level     = level_v;
  assign bus.press         = press_v;
  assign bus.release_pulse = rel_v;
  assign bus.long_press    = long_v;
  assign bus.repeat_pulse  = rpt_v;
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench: two conditioners (active-high and active-low raw inputs)
// driven by one clock, checked cycle by cycle against hand-timed events.
module tb_btn_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   npass = 0;
  int   nfail = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  btn_if #(.NUM_BTN(2)) a ();
  btn_if #(.NUM_BTN(2)) b ();

  btn_conditioner #(
    .NUM_BTN(2), .DEBOUNCE_CYC(4), .LONG_CYC(20),
    .REPEAT_CYC(5), .ACTIVE_LOW(0)
  ) u_a (.clk(clk), .rst(rst), .bus(a));

  btn_conditioner #(
    .NUM_BTN(2), .DEBOUNCE_CYC(4), .LONG_CYC(20),
    .REPEAT_CYC(5), .ACTIVE_LOW(1)
  ) u_b (.clk(clk), .rst(rst), .bus(b));

  // event vector per lane: {press, release, long_press, repeat}
  logic [3:0] ev_a0, ev_a1, ev_b0, ev_b1;
  logic [9:0] all_a, all_b;
  assign ev_a0 = {a.press[0], a.release_pulse[0],
                  a.long_press[0], a.repeat_pulse[0]};
  assign ev_a1 = {a.press[1], a.release_pulse[1],
                  a.long_press[1], a.repeat_pulse[1]};
  assign ev_b0 = {b.press[0], b.release_pulse[0],
                  b.long_press[0], b.repeat_pulse[0]};
  assign ev_b1 = {b.press[1], b.release_pulse[1],
                  b.long_press[1], b.repeat_pulse[1]};
  assign all_a = {a.btn_level, a.press, a.release_pulse,
                  a.long_press, a.repeat_pulse};
  assign all_b = {b.btn_level, b.press, b.release_pulse,
                  b.long_press, b.repeat_pulse};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step from..to cycles; k is the cycle index relative to the caller's
  // reference edge. Times < 0 mean "never". Repeats every 5 from r0 until
  // release; rskip excludes the repeat bit at one cycle.
  task automatic win(input string tag, input bit sel,
                     input int from, input int to,
                     input int tp, input int tr, input int tl,
                     input int r0, input int rskip);
    logic [3:0] exp;
    logic [3:0] obs;
    for (int k = from; k <= to; k++) begin
      step();
      exp = {k == tp, k == tr, k == tl, 1'b0};
      exp[0] = (r0 > 0) && (k >= r0) && (((k - r0) % 5) == 0)
               && (tr < 0 || k < tr);
      obs = sel ? ev_b0 : ev_a0;
      if (k == rskip) begin
        exp[0] = obs[0];
      end
      chk($sformatf("%s_k%0d", tag, k), 16'(obs), 16'(exp));
      chk($sformatf("%s_other_k%0d", tag, k),
          16'(sel ? ev_b1 : ev_a1), 16'h0);
    end
  endtask

  logic [9:0] pat;

  initial begin
    a.btn = 2'b11;
    b.btn = 2'b00;
    rst   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_a%0d", i), 16'(all_a), 16'h0);
      chk($sformatf("rst_b%0d", i), 16'(all_b), 16'h0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("rst_early%0d", i), 16'(a.press), 16'h0);
    end
    step();
    chk("rst_press_a", 16'(a.press), 16'h3);
    chk("rst_level_a", 16'(a.btn_level), 16'h3);
    chk("rst_press_b", 16'(b.press), 16'h3);

    a.btn = 2'b00;
    for (int i = 0; i < 6; i++) step();
    chk("rst_release_a", 16'(a.release_pulse), 16'h3);

    // bounce: highs of 1, 2, 3 cycles with 1-cycle lows
    pat = 10'b0111011010;
    for (int i = 0; i < 9; i++) begin
      a.btn[0] = pat[i + 1];
      win("bounce", 1'b0, 1, 1, -1, -1, -1, -1, -1);
    end
    a.btn[0] = 1'b1;
    win("bounce_end", 1'b0, 1, 6, 6, -1, -1, -1, -1);

    // long press and repeat, then release
    win("long", 1'b0, 1, 38, -1, -1, 20, 25, -1);
    a.btn[0] = 1'b0;
    win("long_rel", 1'b0, 39, 44, -1, 44, 20, 25, -1);
    win("idle", 1'b0, 1, 2, -1, -1, -1, -1, -1);

    // release while repeating
    a.btn[0] = 1'b1;
    win("rp_press", 1'b0, 1, 6, 6, -1, -1, -1, -1);
    win("rp_hold", 1'b0, 1, 27, -1, -1, 20, 25, -1);
    a.btn[0] = 1'b0;
    win("rp_rel", 1'b0, 28, 36, -1, 33, 20, 25, 30);
    a.btn[0] = 1'b1;
    win("repush", 1'b0, 1, 6, 6, -1, -1, -1, -1);
    a.btn[0] = 1'b0;
    win("repush_rel", 1'b0, 1, 6, -1, 6, -1, -1, -1);

    // level falls on the exact long_press cycle
    a.btn[0] = 1'b1;
    win("col_press", 1'b0, 1, 6, 6, -1, -1, -1, -1);
    win("col_hold", 1'b0, 1, 14, -1, -1, -1, -1, -1);
    a.btn[0] = 1'b0;
    win("col_rel", 1'b0, 15, 22, -1, 20, -1, -1, -1);

    // active-low lane 0 held while lane 1 bounces
    b.btn = 2'b11;
    rst   = 1'b1;
    step();
    chk("rst2_b", 16'(all_b), 16'h0);
    chk("rst2_a", 16'(all_a), 16'h0);
    rst = 1'b0;
    b.btn[0] = 1'b0;
    pat = 10'b1100010010;
    for (int k = 1; k <= 40; k++) begin
      b.btn[1] = (k <= 10) ? pat[k - 1] : 1'b1;
      win("indep", 1'b1, k, k, 6, -1, 26, 31, -1);
    end
    chk("indep_level", 16'(b.btn_level), 16'h1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
